// File: rtl/multi_port_sram_arbiter.sv
// Round-robin front end that shares one single-port SRAM among N requesters
// and routes each read response back to its issuer after a fixed latency.
module multi_port_sram_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned W   = 32,
    parameter int unsigned AW  = 8,
    parameter int unsigned LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_vld,
    input  logic [N-1:0]    req_wen,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N*W-1:0]  req_wdata,
    output logic [N-1:0]    req_gnt,
    output logic [N-1:0]    rsp_vld,
    output logic [W-1:0]    rsp_rdata,
    output logic            sram_en,
    output logic            sram_wen,
    output logic [AW-1:0]   sram_addr,
    output logic [W-1:0]    sram_wdata,
    input  logic [W-1:0]    sram_rdata
);

    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win;
    logic           any_gnt;
    logic [IDW:0]   scan;

    logic           pipe_vld [LAT];
    logic [IDW-1:0] pipe_id  [LAT];

    // Rotating priority scan starting at ptr; reset masks every grant.
    always_comb begin
        req_gnt = '0;
        win     = '0;
        any_gnt = 1'b0;
        scan    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            scan = {1'b0, ptr} + (IDW+1)'(k);
            if (scan >= (IDW+1)'(N)) begin
                scan = scan - (IDW+1)'(N);
            end
            if (!any_gnt && req_vld[IDW'(scan)]) begin
                any_gnt = 1'b1;
                win     = IDW'(scan);
            end
        end
        if (rst) begin
            any_gnt = 1'b0;
        end
        if (any_gnt) begin
            req_gnt[win] = 1'b1;
        end
    end

    // Next scan starts just past the most recent winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (any_gnt) begin
            ptr <= (win == IDW'(N - 1)) ? '0 : win + IDW'(1);
        end
    end

    // Winner's request goes straight to the macro; idle cycles drive zeros.
    always_comb begin
        sram_en    = any_gnt;
        sram_wen   = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (any_gnt) begin
            sram_wen   = req_wen[win];
            sram_addr  = req_addr[32'(win)*AW +: AW];
            sram_wdata = req_wdata[32'(win)*W +: W];
        end
    end

    // Read tag pipeline, aligned so the last stage meets sram_rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < LAT; s++) begin
                pipe_vld[s] <= 1'b0;
                pipe_id[s]  <= '0;
            end
        end else begin
            pipe_vld[0] <= any_gnt && !sram_wen;
            pipe_id[0]  <= win;
            for (int unsigned s = 1; s < LAT; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_id[s]  <= pipe_id[s-1];
            end
        end
    end

    always_comb begin
        rsp_vld   = '0;
        rsp_rdata = sram_rdata;
        if (pipe_vld[LAT-1]) begin
            rsp_vld[pipe_id[LAT-1]] = 1'b1;
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) $onehot0(req_gnt));
    a_rsp_onehot: assert property (@(posedge clk) $onehot0(rsp_vld));

    // Requesters must hold a pending request until it is granted.
    for (genvar i = 0; i < N; i++) begin : g_hold
        a_req_hold: assert property (@(posedge clk) disable iff (rst)
            (req_vld[i] && !req_gnt[i]) |=>
                (req_vld[i] && $stable(req_wen[i]) &&
                 $stable(req_addr[i*AW +: AW]) && $stable(req_wdata[i*W +: W])));
    end

endmodule

// File: tb/tb_multi_port_sram_arbiter.sv
// Bench for multi_port_sram_arbiter: three instances (LAT 1,2,3) share one
// stimulus stream and are checked against a rule-level model every cycle.
module tb_multi_port_sram_arbiter;

    localparam int N    = 4;
    localparam int W    = 32;
    localparam int AW   = 8;
    localparam int NI   = 3;
    localparam int HMAX = 1024;
    localparam logic [N-1:0] ONE = 1;

    typedef struct {
        logic          wen;
        logic [AW-1:0] addr;
        logic [W-1:0]  wdata;
    } op_t;

    typedef struct {
        int           due;
        int           id;
        logic [W-1:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_vld = '0;
    logic [N-1:0]    req_wen = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*W-1:0]  req_wdata = '0;

    logic [N-1:0]  gnt_w    [NI];
    logic [N-1:0]  rspv_w   [NI];
    logic [W-1:0]  rdat_w   [NI];
    logic          sen_w    [NI];
    logic          swen_w   [NI];
    logic [AW-1:0] saddr_w  [NI];
    logic [W-1:0]  swdata_w [NI];
    logic [W-1:0]  srdata_w [NI];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    op_t  opq  [N][$];
    exp_t expq [NI][$];
    logic [W-1:0] ref_mem [256];
    int           ptr_m    = 0;
    logic         rst_prev = 1'b1;
    logic [N-1:0] gnt_seen = '0;

    logic [N-1:0] gnt_h  [HMAX];
    logic [N-1:0] rsp_h  [NI][HMAX];
    logic [W-1:0] rdat_h [NI][HMAX];

    always #5 clk = ~clk;

    function automatic logic [W-1:0] init_word(input int a);
        return (a == 5) ? 32'hA5 : 32'h5A00_0000 + 32'(a);
    endfunction

    // DUT instances with a simple latency-LAT SRAM behind each.
    for (genvar k = 0; k < NI; k++) begin : g_inst
        localparam int unsigned L = k + 1;
        logic [W-1:0] mem     [256];
        logic [W-1:0] rd_pipe [L];

        multi_port_sram_arbiter #(.N(N), .W(W), .AW(AW), .LAT(L)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_vld    (req_vld),
            .req_wen    (req_wen),
            .req_addr   (req_addr),
            .req_wdata  (req_wdata),
            .req_gnt    (gnt_w[k]),
            .rsp_vld    (rspv_w[k]),
            .rsp_rdata  (rdat_w[k]),
            .sram_en    (sen_w[k]),
            .sram_wen   (swen_w[k]),
            .sram_addr  (saddr_w[k]),
            .sram_wdata (swdata_w[k]),
            .sram_rdata (srdata_w[k])
        );

        initial begin
            for (int a = 0; a < 256; a++) mem[a] = init_word(a);
        end

        always @(posedge clk) begin
            if (sen_w[k] && swen_w[k]) mem[saddr_w[k]] <= swdata_w[k];
            rd_pipe[0] <= mem[saddr_w[k]];
            for (int j = 1; j < int'(L); j++) rd_pipe[j] <= rd_pipe[j-1];
        end

        assign srdata_w[k] = rd_pipe[L-1];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Per-cycle model: rotating-priority winner, memory image, response schedule.
    always @(negedge clk) begin : cmp
        int best, bestd, d;
        logic [N-1:0]  eg, er;
        logic [AW-1:0] a;
        exp_t e;
        gnt_h[cyc] = gnt_w[0];
        for (int k = 0; k < NI; k++) begin
            rsp_h[k][cyc]  = rspv_w[k];
            rdat_h[k][cyc] = rdat_w[k];
        end
        if (rst) begin
            for (int k = 0; k < NI; k++) begin
                chk("rst_gnt", 64'(gnt_w[k]), 0);
                chk("rst_sram_en", 64'(sen_w[k]), 0);
                if (rst_prev) chk("rst_rsp_vld", 64'(rspv_w[k]), 0);
                expq[k].delete();
            end
            ptr_m = 0;
        end else begin
            best  = -1;
            bestd = N;
            for (int i = 0; i < N; i++) begin
                if (req_vld[i]) begin
                    d = (i - ptr_m + N) % N;
                    if (d < bestd) begin
                        bestd = d;
                        best  = i;
                    end
                end
            end
            eg = (best >= 0) ? (ONE << best) : '0;
            for (int k = 0; k < NI; k++) begin
                chk("gnt", 64'(gnt_w[k]), 64'(eg));
                chk("sram_en", 64'(sen_w[k]), 64'(best >= 0));
                if (best >= 0) begin
                    chk("sram_wen", 64'(swen_w[k]), 64'(req_wen[best]));
                    chk("sram_addr", 64'(saddr_w[k]), 64'(req_addr[best*AW +: AW]));
                    chk("sram_wdata", 64'(swdata_w[k]), 64'(req_wdata[best*W +: W]));
                end
                er = '0;
                if (expq[k].size() > 0 && expq[k][0].due == cyc) begin
                    e  = expq[k].pop_front();
                    er = ONE << e.id;
                    chk("rsp_rdata", 64'(rdat_w[k]), 64'(e.data));
                end
                chk("rsp_vld", 64'(rspv_w[k]), 64'(er));
            end
            if (best >= 0) begin
                a = req_addr[best*AW +: AW];
                if (req_wen[best]) begin
                    ref_mem[a] = req_wdata[best*W +: W];
                end else begin
                    for (int k = 0; k < NI; k++) expq[k].push_back('{cyc + k + 1, best, ref_mem[a]});
                end
                ptr_m = (best + 1) % N;
            end
        end
        rst_prev = rst;
        gnt_seen = gnt_w[0];
        cyc++;
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (opq[i].size() > 0) begin
                req_vld[i]              = 1'b1;
                req_wen[i]              = opq[i][0].wen;
                req_addr[i*AW +: AW]    = opq[i][0].addr;
                req_wdata[i*W +: W]     = opq[i][0].wdata;
            end else begin
                req_vld[i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (gnt_seen[i] && opq[i].size() > 0) void'(opq[i].pop_front());
        end
        drive();
    endtask

    task automatic push(input int i, input logic wen, input int addr, input logic [W-1:0] data);
        opq[i].push_back('{wen, 8'(addr), data});
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (opq[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (!all_empty() && n < 200) begin
            tick();
            n++;
        end
        chk("idle_timeout", 64'(n < 200), 1);
        repeat (6) tick();
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        repeat (ncyc) tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin : main
        int s;
        for (int a = 0; a < 256; a++) ref_mem[a] = init_word(a);
        do_reset(3);

        // Single read from requester 2.
        s = cyc;
        push(2, 1'b0, 5, '0);
        drive();
        wait_idle();
        chk("t1_gnt", 64'(gnt_h[s]), 64'(4'b0100));
        chk("t1_rsp_lat1", 64'(rsp_h[0][s+1]), 64'(4'b0100));
        chk("t1_data_lat1", 64'(rdat_h[0][s+1]), 64'h0A5);
        chk("t1_rsp_lat3", 64'(rsp_h[2][s+3]), 64'(4'b0100));

        // All four requesters streaming from ptr=0.
        do_reset(2);
        s = cyc;
        for (int i = 0; i < N; i++) begin
            push(i, 1'b1, 16 + i, 32'h1000 + 32'(i));
            push(i, 1'b0, 16 + i, '0);
        end
        drive();
        wait_idle();
        for (int k = 0; k < 8; k++) chk("t2_rr_order", 64'(gnt_h[s+k]), 64'(ONE << (k % 4)));
        for (int j = 0; j < N; j++) begin
            chk("t2_rsp", 64'(rsp_h[0][s+5+j]), 64'(ONE << j));
            chk("t2_data", 64'(rdat_h[0][s+5+j]), 64'h1000 + 64'(j));
        end

        // Write then read of the same address by different requesters.
        s = cyc;
        push(1, 1'b1, 9, 32'h1234);
        push(3, 1'b0, 9, '0);
        drive();
        wait_idle();
        chk("t3_gnt_w", 64'(gnt_h[s]), 64'(4'b0010));
        chk("t3_gnt_r", 64'(gnt_h[s+1]), 64'(4'b1000));
        chk("t3_rsp", 64'(rsp_h[0][s+2]), 64'(4'b1000));
        chk("t3_data", 64'(rdat_h[0][s+2]), 64'h1234);
        chk("t3_data_lat3", 64'(rdat_h[2][s+4]), 64'h1234);

        // Back-to-back reads seen through the LAT=3 instance.
        s = cyc;
        push(0, 1'b0, 5, '0);
        push(1, 1'b0, 9, '0);
        push(2, 1'b0, 16, '0);
        drive();
        wait_idle();
        chk("t4_rsp0", 64'(rsp_h[2][s+3]), 64'(4'b0001));
        chk("t4_data0", 64'(rdat_h[2][s+3]), 64'h0A5);
        chk("t4_rsp1", 64'(rsp_h[2][s+4]), 64'(4'b0010));
        chk("t4_data1", 64'(rdat_h[2][s+4]), 64'h1234);
        chk("t4_rsp2", 64'(rsp_h[2][s+5]), 64'(4'b0100));
        chk("t4_data2", 64'(rdat_h[2][s+5]), 64'h1000);

        // Requester 0 held while 1..3 keep retriggering, starting from ptr=1.
        push(0, 1'b0, 0, '0);
        drive();
        wait_idle();
        s = cyc;
        for (int j = 0; j < 4; j++) begin
            push(0, 1'b0, 20 + j, '0);
            for (int i = 1; i < N; i++) push(i, 1'b1, 32 + i*4 + j, {24'h0, 8'(i*16 + j)});
        end
        drive();
        wait_idle();
        chk("t5_req0_by_4", 64'(gnt_h[s+3]), 64'(4'b0001));
        for (int k = 0; k < 16; k++) chk("t5_wrap", 64'(gnt_h[s+k]), 64'(ONE << ((k + 1) % 4)));

        // Reset with two reads in flight.
        s = cyc;
        push(1, 1'b0, 9, '0);
        push(2, 1'b0, 5, '0);
        drive();
        tick();
        tick();
        do_reset(2);
        repeat (5) tick();
        chk("t6_gnt_a", 64'(gnt_h[s]), 64'(4'b0010));
        chk("t6_gnt_b", 64'(gnt_h[s+1]), 64'(4'b0100));
        for (int c = s + 3; c <= s + 8; c++) begin
            for (int k = 0; k < NI; k++) chk("t6_no_rsp", 64'(rsp_h[k][c]), 0);
        end
        s = cyc;
        push(3, 1'b0, 9, '0);
        push(1, 1'b0, 5, '0);
        drive();
        wait_idle();
        chk("t6_first_gnt", 64'(gnt_h[s]), 64'(4'b0010));
        chk("t6_second_gnt", 64'(gnt_h[s+1]), 64'(4'b1000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
